// File: rtl/turing_engine_pkg.sv
// Shared types for the Turing machine engine: head move codes, rule entry, controller states.
// Rule fields are carried at the maximum supported widths. Each module zero-extends or
// truncates them to its own SW/QW. SW must not exceed SYM_W_MAX, and QW must not exceed STATE_W_MAX.
package turing_engine_pkg;

  // Default widths used when a module does not override them.
  localparam int SW_DEF      = 1;
  localparam int QW_DEF      = 4;
  // Widest symbol / state the rule container can carry.
  localparam int SYM_W_MAX   = 8;
  localparam int STATE_W_MAX = 8;

  typedef enum logic [1:0] {
    MV_RIGHT = 2'b00,
    MV_LEFT  = 2'b01,
    MV_STAY  = 2'b10,
    MV_HALT  = 2'b11
  } move_t;

  typedef struct packed {
    logic [SYM_W_MAX-1:0]   wsym;
    move_t                  move;
    logic [STATE_W_MAX-1:0] next;
  } rule_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_PAUSE,
    ST_DONE
  } ctrl_state_t;

  // Step counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/turing_rule_ram.sv
// Rule table: 2^(QW+SW) entries, indexed {state, symbol}.
// Single write port and synchronous read; the read data is valid the cycle after re.
// Contents are not reset. Only the SW+2+QW meaningful bits of each entry are stored.
module turing_rule_ram
  import turing_engine_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int QW = QW_DEF
) (
  input  logic            clock,
  input  logic            we,
  input  logic [QW+SW-1:0] waddr,
  input  rule_t           wrule,
  input  logic            re,
  input  logic [QW+SW-1:0] raddr,
  output rule_t           rrule
);

  localparam int RW    = SW + 2 + QW;
  localparam int DEPTH = 2 ** (QW + SW);

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rword;

  // Table write, narrowed to the configured widths.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= {SW'(wrule.wsym), wrule.move, QW'(wrule.next)};
  end

  // Registered read.
  always_ff @(posedge clock) begin
    if (re) rword <= mem[raddr];
  end

  // Widen the stored word back into the shared rule container.
  always_comb begin
    rrule      = '0;
    rrule.wsym = SYM_W_MAX'(rword[RW-1 -: SW]);
    rrule.move = move_t'(rword[QW +: 2]);
    rrule.next = STATE_W_MAX'(rword[QW-1:0]);
  end

endmodule

// File: rtl/turing_engine.sv
// Single-tape Turing machine engine with a loadable rule table and free-run or single-step control.
// One step takes 2 cycles (FETCH, EXEC) in free-run, and 3 cycles per step with step held high in step mode.
// Host rule and tape writes are dropped while busy. Defining TURING_ENGINE_STEP_LIMIT_EN adds MAX_STEPS and timeout.
module turing_engine
  import turing_engine_pkg::*;
#(
  parameter int SW        = SW_DEF,
  parameter int QW        = QW_DEF,
  parameter int TAPE_LEN  = 32,
  parameter int HEAD_INIT = 0,
`ifdef TURING_ENGINE_STEP_LIMIT_EN
  parameter int MAX_STEPS = 1000,
`endif
  localparam int AW       = $clog2(TAPE_LEN)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rule_we,
  input  logic [QW-1:0] rule_q,
  input  logic [SW-1:0] rule_sym,
  input  logic [SW-1:0] rule_wsym,
  input  logic [1:0]    rule_move,
  input  logic [QW-1:0] rule_next,
  input  logic          tape_we,
  input  logic [AW-1:0] tape_addr,
  input  logic [SW-1:0] tape_wdata,
  output logic [SW-1:0] tape_rdata,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic          timeout,
  output logic [QW-1:0] state,
  output logic [AW-1:0] head,
  output logic [15:0]   step_count
);

  localparam logic [AW-1:0] HEAD_START = AW'(HEAD_INIT);
  localparam logic [AW-1:0] HEAD_MAX   = AW'(TAPE_LEN - 1);

  ctrl_state_t   ctrl, ctrl_nxt;
  logic [SW-1:0] tape [TAPE_LEN];
  logic [SW-1:0] cur_sym;
  rule_t         wr_rule, cur_rule;
  logic [SW-1:0] cur_wsym;
  logic [QW-1:0] cur_next;
  move_t         cur_move;
  logic [15:0]   count_inc;
  logic          launch, exec_halt, exec_fault, exec_tmo, exec_stop;

  assign launch     = start && (ctrl == ST_IDLE || ctrl == ST_DONE);
  assign cur_sym    = tape[head];
  assign tape_rdata = tape[tape_addr];

  assign wr_rule = '{wsym: SYM_W_MAX'(rule_wsym), move: move_t'(rule_move),
                     next: STATE_W_MAX'(rule_next)};

  // The rule lookup is issued in FETCH and consumed in EXEC.
  turing_rule_ram #(.SW(SW), .QW(QW)) u_rules (
    .clock (clock),
    .we    (rule_we && !busy),
    .waddr ({rule_q, rule_sym}),
    .wrule (wr_rule),
    .re    (ctrl == ST_FETCH),
    .raddr ({state, cur_sym}),
    .rrule (cur_rule)
  );

  assign cur_wsym  = SW'(cur_rule.wsym);
  assign cur_next  = QW'(cur_rule.next);
  assign cur_move  = cur_rule.move;
  assign count_inc = sat_inc16(step_count);

  // A halt rule or an out-of-bounds move ends the run. Both take priority over the step limit.
  assign exec_halt  = (cur_move == MV_HALT);
  assign exec_fault = (cur_move == MV_RIGHT && head == HEAD_MAX) ||
                      (cur_move == MV_LEFT  && head == '0);
`ifdef TURING_ENGINE_STEP_LIMIT_EN
  assign exec_tmo   = !exec_halt && !exec_fault && (count_inc == 16'(MAX_STEPS));
`else
  assign exec_tmo   = 1'b0;
`endif
  assign exec_stop  = exec_halt || exec_fault || exec_tmo;

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ctrl <= ST_IDLE;
    else       ctrl <= ctrl_nxt;
  end

  // Controller next-state logic.
  always_comb begin
    ctrl_nxt = ctrl;
    case (ctrl)
      ST_IDLE, ST_DONE: if (start) ctrl_nxt = ST_FETCH;
      ST_FETCH:         ctrl_nxt = ST_EXEC;
      ST_EXEC: begin
        if (exec_stop)      ctrl_nxt = ST_DONE;
        else if (step_mode) ctrl_nxt = ST_PAUSE;
        else                ctrl_nxt = ST_FETCH;
      end
      ST_PAUSE:         if (step) ctrl_nxt = ST_FETCH;
      default:          ctrl_nxt = ST_IDLE;
    endcase
  end

  // Controller outputs.
  always_comb begin
    busy = (ctrl == ST_FETCH) || (ctrl == ST_EXEC) || (ctrl == ST_PAUSE);
  end

  // Machine registers: cleared on start, committed in EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= '0;
      head       <= '0;
      step_count <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else if (launch) begin
      state      <= '0;
      head       <= HEAD_START;
      step_count <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else if (ctrl == ST_EXEC) begin
      state      <= cur_next;
      step_count <= count_inc;
      if (exec_halt)  halted <= 1'b1;
      if (exec_fault) fault  <= 1'b1;
      if (cur_move == MV_RIGHT && !exec_fault) head <= head + AW'(1);
      if (cur_move == MV_LEFT  && !exec_fault) head <= head - AW'(1);
    end
  end

`ifdef TURING_ENGINE_STEP_LIMIT_EN
  // Step-limit flag, set on the EXEC edge of step MAX_STEPS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          timeout <= 1'b0;
    else if (launch)                    timeout <= 1'b0;
    else if (ctrl == ST_EXEC && exec_tmo) timeout <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Tape: the machine writes in EXEC, and the host writes only while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
    end else if (ctrl == ST_EXEC) begin
      tape[head] <= cur_wsym;
    end else if (tape_we && !busy) begin
      tape[tape_addr] <= tape_wdata;
    end
  end

endmodule

// File: tb/tb_turing_engine.sv
// Directed bench for turing_engine (SW=1, QW=2, 8 cells): incrementer, fault, step mode,
// writes while busy, reset mid-run with restart, and endless loop / step limit.
module tb_turing_engine;

  localparam int SW = 1, QW = 2, TAPE_LEN = 8, AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rule_we = 1'b0, tape_we = 1'b0, start = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [QW-1:0] rule_q = '0, rule_next = '0;
  logic [SW-1:0] rule_sym = '0, rule_wsym = '0, tape_wdata = '0;
  logic [1:0]    rule_move = '0;
  logic [AW-1:0] tape_addr = '0;
  logic [SW-1:0] tape_rdata;
  logic          busy, halted, fault, timeout;
  logic [QW-1:0] state;
  logic [AW-1:0] head;
  logic [15:0]   step_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clock = ~clock;

  turing_engine #(
    .SW(SW), .QW(QW), .TAPE_LEN(TAPE_LEN), .HEAD_INIT(0)
`ifdef TURING_ENGINE_STEP_LIMIT_EN
    , .MAX_STEPS(10)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .rule_we(rule_we), .rule_q(rule_q), .rule_sym(rule_sym), .rule_wsym(rule_wsym),
    .rule_move(rule_move), .rule_next(rule_next),
    .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata), .tape_rdata(tape_rdata),
    .start(start), .step_mode(step_mode), .step(step),
    .busy(busy), .halted(halted), .fault(fault), .timeout(timeout),
    .state(state), .head(head), .step_count(step_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tape(input string tag, input int a, input int exp);
    tape_addr = AW'(a);
    #1;
    check(tag, 32'(tape_rdata), exp);
  endtask

  task automatic load_rule(input int q, input int s, input int w, input int mv, input int nx);
    rule_q = QW'(q); rule_sym = SW'(s); rule_wsym = SW'(w); rule_move = 2'(mv); rule_next = QW'(nx);
    rule_we = 1'b1;
    tick();
    rule_we = 1'b0;
  endtask

  task automatic write_tape(input int a, input int d);
    tape_addr = AW'(a); tape_wdata = SW'(d);
    tape_we = 1'b1;
    tick();
    tape_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  task automatic check_regs(input string tag, input int cnt, input int q, input int h);
    check({tag, "_count"}, 32'(step_count), cnt);
    check({tag, "_state"}, 32'(state), q);
    check({tag, "_head"},  32'(head), h);
  endtask

  // Expected outcome of the 14-step right-walking run (it faults at the last cell, or times out at step 10).
`ifdef TURING_ENGINE_STEP_LIMIT_EN
  localparam int RUN_CYC = 12, RUN_CNT = 10, RUN_Q = 2, RUN_H = 6, RUN_FLT = 0, RUN_TMO = 1;
  localparam logic [7:0] RUN_TAPE = 8'b0010_1011;
`else
  localparam int RUN_CYC = 20, RUN_CNT = 14, RUN_Q = 2, RUN_H = 7, RUN_FLT = 1, RUN_TMO = 0;
  localparam logic [7:0] RUN_TAPE = 8'b1010_1011;
`endif

  initial begin
    logic [7:0] exp_tape;

    // ---- reset state ----
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_timeout", 32'(timeout), 0);
    check_regs("rst", 0, 0, 0);
    check_tape("rst_tape0", 0, 0);

    // ---- binary incrementer: 1,1,0 -> 0,0,1 ----
    load_rule(0, 1, 0, 0, 0);   // carry: write 0, move right
    load_rule(0, 0, 1, 3, 1);   // absorb: write 1, halt
    write_tape(0, 1); write_tape(1, 1); write_tape(2, 0);
    do_start();
    check("inc_busy_rise", 32'(busy), 1);
    wait_idle("inc_done", 100, cyc);
    check("inc_busy_cycles", cyc, 6);
    check("inc_halted", 32'(halted), 1);
    check("inc_fault", 32'(fault), 0);
    check_regs("inc", 3, 1, 2);
    check_tape("inc_tape0", 0, 0);
    check_tape("inc_tape1", 1, 0);
    check_tape("inc_tape2", 2, 1);

    // ---- left move at cell 0 faults ----
    write_tape(0, 0);
    load_rule(0, 0, 1, 1, 2);
    do_start();
    wait_idle("flt_done", 20, cyc);
    check("flt_cycles", cyc, 2);
    check("flt_fault", 32'(fault), 1);
    check("flt_halted", 32'(halted), 0);
    check_regs("flt", 1, 2, 0);
    check_tape("flt_tape0", 0, 1);

    // ---- walker program, single-stepped ----
    reset = 1'b1; tick(); reset = 1'b0; tick();
    load_rule(0, 0, 1, 0, 1); load_rule(1, 0, 1, 0, 2);
    load_rule(2, 0, 1, 0, 3); load_rule(3, 0, 0, 1, 0);
    load_rule(0, 1, 0, 0, 1); load_rule(1, 1, 1, 0, 2);
    load_rule(2, 1, 1, 0, 3); load_rule(3, 1, 0, 1, 0);
    step_mode = 1'b1;
    do_start();
    tick(); tick();
    check_regs("stp1", 1, 1, 1);
    check("stp1_busy", 32'(busy), 1);
    do_step();
    check_regs("stp2", 2, 2, 2);
    do_step();
    check_regs("stp3", 3, 3, 3);
    check_tape("stp3_tape2", 2, 1);
    do_step();
    check_regs("stp4", 4, 0, 2);
    check("stp4_busy", 32'(busy), 1);

    // ---- host writes and start while paused are ignored ----
    write_tape(0, 0);
    load_rule(0, 0, 0, 3, 3);
    check_tape("busy_tape0", 0, 1);
    do_start();
    check_regs("busy_start", 4, 0, 2);
    check("busy_still", 32'(busy), 1);
    do_step();
    check_regs("stp5", 5, 1, 3);
    check_tape("stp5_tape2", 2, 0);

    // ---- reset during EXEC of step 5 ----
    reset = 1'b1; tick(); reset = 1'b0; tick();
    step_mode = 1'b0;
    do_start();
    repeat (9) tick();
    check_regs("pre_rst", 4, 0, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_halted", 32'(halted), 0);
    check_regs("mid_rst", 0, 0, 0);
    check_tape("mid_rst_tape0", 0, 0);
    check_tape("mid_rst_tape1", 1, 0);
    check_tape("mid_rst_tape2", 2, 0);
    tick();
    reset = 1'b0;
    tick();

    // ---- restart with retained rules reproduces the run ----
    do_start();
    repeat (8) tick();
    check_regs("re4", 4, 0, 2);
    check("re4_halted", 32'(halted), 0);
    wait_idle("run_done", 100, cyc);
    check("run_cycles", cyc, RUN_CYC);
    check("run_fault", 32'(fault), RUN_FLT);
    check("run_timeout", 32'(timeout), RUN_TMO);
    check("run_halted", 32'(halted), 0);
    check_regs("run", RUN_CNT, RUN_Q, RUN_H);
    exp_tape = RUN_TAPE;
    for (int i = 0; i < 8; i++) check_tape($sformatf("run_tape%0d", i), i, int'(exp_tape[i]));

    // ---- two-state loop that never halts ----
    write_tape(0, 0);
    load_rule(0, 0, 0, 2, 1);
    load_rule(1, 0, 0, 2, 0);
    do_start();
`ifdef TURING_ENGINE_STEP_LIMIT_EN
    wait_idle("loop_done", 200, cyc);
    check("loop_cycles", cyc, 20);
    check("loop_timeout", 32'(timeout), 1);
    check("loop_count", 32'(step_count), 10);
    check("loop_halted", 32'(halted), 0);
    check("loop_fault", 32'(fault), 0);
`else
    repeat (1000) tick();
    check("loop_busy", 32'(busy), 1);
    check("loop_timeout", 32'(timeout), 0);
    check("loop_count", 32'(step_count), 500);
`endif
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
